// File: rtl/noc_vc_buffer_pkg.sv
// Shared NoC parameters, packet-state encoding and stored-entry layout for the VC input buffer.
package noc_vc_buffer_pkg;

    localparam int Noc_Data_Width = 32;
    localparam int Noc_VC_Channel = 4;
    localparam int Noc_VC_Depth   = 4;

    localparam logic [1:0] VCB_IDLE  = 2'd0;
    localparam logic [1:0] VCB_OPEN  = 2'd1;
    localparam logic [1:0] VCB_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        VCB_ST_IDLE  = VCB_IDLE,
        VCB_ST_OPEN  = VCB_OPEN,
        VCB_ST_DRAIN = VCB_DRAIN
    } vcb_state_t;

    // Flag bits sit directly above the payload: entry = {is_tail, is_header, flit}.
    localparam int VCB_HDR_OFS  = 0;
    localparam int VCB_TAIL_OFS = 1;
    localparam int VCB_FLAG_W   = 2;

    function automatic int vcb_entry_width(input int data_width);
        return data_width + VCB_FLAG_W;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// First-word-fall-through synchronous FIFO: the head entry is read straight out of storage.
module noc_sync_fifo #(
    parameter  int WIDTH = 34,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             noc_clk,
    input  logic             noc_rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge noc_clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

endmodule

// File: rtl/noc_vc_buffer.sv
// Per-VC input buffer: FWFT flit storage plus wormhole packet tracking that drives VCready.
module noc_vc_buffer
    import noc_vc_buffer_pkg::*;
#(
    parameter  int DATA_WIDTH = Noc_Data_Width,
    parameter  int DEPTH      = Noc_VC_Depth,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst,
    input  logic                  Noc_in_valid,
    output logic                  Noc_in_ready,
    input  logic [DATA_WIDTH-1:0] Noc_in_flit,
    input  logic                  Noc_in_is_header,
    input  logic                  Noc_in_is_tail,
    output logic                  Noc_in_VCready,
    output logic                  Noc_out_valid,
    input  logic                  Noc_out_ready,
    output logic [DATA_WIDTH-1:0] Noc_out_flit,
    output logic                  Noc_out_is_header,
    output logic                  Noc_out_is_tail,
    output logic [PTR_W:0]        Noc_occupancy,
    output logic                  Noc_proto_err
);

    localparam int ENTRY_W = vcb_entry_width(DATA_WIDTH);

    // push = in_valid & in_ready, pop = out_valid & out_ready; both readies/valids
    // come from registered FIFO count only, so no combinational in-to-out path exists.
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    vcb_state_t         state;

    assign push = Noc_in_valid & Noc_in_ready;
    assign pop  = Noc_out_valid & Noc_out_ready;

    assign wr_entry = {Noc_in_is_tail, Noc_in_is_header, Noc_in_flit};

    noc_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .noc_clk (noc_clk),
        .noc_rst (noc_rst),
        .push    (push),
        .pop     (pop),
        .wdata   (wr_entry),
        .rdata   (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (Noc_occupancy)
    );

    assign Noc_in_ready      = ~fifo_full;
    assign Noc_out_valid     = ~fifo_empty;
    assign Noc_out_flit      = rd_entry[DATA_WIDTH-1:0];
    assign Noc_out_is_header = rd_entry[DATA_WIDTH + VCB_HDR_OFS];
    assign Noc_out_is_tail   = rd_entry[DATA_WIDTH + VCB_TAIL_OFS];

    // Malformed flits are still stored; they only raise the sticky error flag.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state         <= VCB_ST_IDLE;
            Noc_proto_err <= 1'b0;
        end else if (push) begin
            case (state)
                VCB_ST_IDLE: begin
                    if (!Noc_in_is_header)   Noc_proto_err <= 1'b1;
                    else if (Noc_in_is_tail) state <= VCB_ST_DRAIN;
                    else                     state <= VCB_ST_OPEN;
                end
                VCB_ST_OPEN: begin
                    if (Noc_in_is_header) Noc_proto_err <= 1'b1;
                    if (Noc_in_is_tail)   state <= VCB_ST_DRAIN;
                end
                VCB_ST_DRAIN: Noc_proto_err <= 1'b1;
                default:      state <= VCB_ST_IDLE;
            endcase
        end else if (state == VCB_ST_DRAIN && fifo_empty) begin
            state <= VCB_ST_IDLE;
        end
    end

    assign Noc_in_VCready = (state == VCB_ST_IDLE) & fifo_empty;

endmodule
